// File: rtl/spu_rf_pkg.sv
// ============================================================================
// Module      : spu_rf_pkg
// Description : Shared types and defaults for the SPU multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spu_rf_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_t;

   localparam int SPU_NUM_REGS = 128;
   localparam int SPU_DATA_W   = 128;

   // Number of cycles the INIT sequence occupies.
   function automatic int clr_cycles(input int num_regs, input int per_cyc);
      return num_regs / per_cyc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spu_rf_bypass.sv
// ============================================================================
// Module      : spu_rf_bypass
// Description : Per-read-port write-through mux; highest enabled write port wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_rf_bypass
   import spu_rf_pkg::*;
#(
   parameter int NUM_WR = 2,
   parameter int ADDR_W = 7,
   parameter int DATA_W = SPU_DATA_W
) (
   input  logic [DATA_W-1:0]              array_word,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
   input  logic [ADDR_W-1:0]              rd_addr,
   output logic [DATA_W-1:0]              rd_data
);

   // Ascending scan so later (higher) ports override earlier matches.
   always_comb begin
      rd_data = array_word;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && (wr_addr[p] == rd_addr)) begin
            rd_data = wr_data[p];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spu_regfile_mp.sv
// ============================================================================
// Module      : spu_regfile_mp
// Description : Parametrised multi-port register file with bypass and clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_regfile_mp
   import spu_rf_pkg::*;
#(
   parameter  int NUM_REGS    = SPU_NUM_REGS,
   parameter  int DATA_W      = SPU_DATA_W,
   parameter  int NUM_RD      = 6,
   parameter  int NUM_WR      = 2,
   parameter  int CLR_PER_CYC = 16,
   localparam int ADDR_W      = $clog2(NUM_REGS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clear_req,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0]   rd_data,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]   wr_data,
   output logic                            ready,
   output logic                            wr_collision
);

   localparam logic [ADDR_W-1:0] c_clr_step = ADDR_W'(CLR_PER_CYC);
   localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(NUM_REGS - CLR_PER_CYC);

   logic [DATA_W-1:0]  r_mem [NUM_REGS];
   rf_state_t          r_state;
   rf_state_t          w_state_nxt;
   logic [ADDR_W-1:0]  r_clr_ptr;
   logic [ADDR_W-1:0]  w_clr_ptr_nxt;
   logic               r_ready;
   logic               w_ready_nxt;
   logic               r_wr_collision;
   logic               w_coll_nxt;
   logic [NUM_WR-1:0]  w_wr_en_run;
   logic [NUM_RD-1:0][DATA_W-1:0] w_byp;

   assign w_wr_en_run  = (r_state == RUN) ? wr_en : '0;
   assign ready        = r_ready;
   assign wr_collision = r_wr_collision;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= INIT;
         r_clr_ptr      <= '0;
         r_ready        <= 1'b0;
         r_wr_collision <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_clr_ptr      <= w_clr_ptr_nxt;
         r_ready        <= w_ready_nxt;
         r_wr_collision <= w_coll_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      case (r_state)
         INIT: begin
            if (r_clr_ptr == c_last_ptr) begin
               w_state_nxt   = RUN;
               w_clr_ptr_nxt = '0;
            end else begin
               w_clr_ptr_nxt = r_clr_ptr + c_clr_step;
            end
         end
         RUN: begin
            if (clear_req) begin
               w_state_nxt   = INIT;
               w_clr_ptr_nxt = '0;
            end
         end
         default: begin
            w_state_nxt   = INIT;
            w_clr_ptr_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_ready_nxt = (w_state_nxt == RUN);
      w_coll_nxt  = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (w_wr_en_run[p] && w_wr_en_run[q] && (wr_addr[p] == wr_addr[q])) begin
               w_coll_nxt = 1'b1;
            end
         end
      end
   end

   // Array has no reset; only the INIT sequence zeroes it. Writes in a reset cycle are dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == INIT) begin
            for (int k = 0; k < CLR_PER_CYC; k++) begin
               r_mem[r_clr_ptr + ADDR_W'(k)] <= '0;
            end
         end else begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_en[p]) begin
                  r_mem[wr_addr[p]] <= wr_data[p];
               end
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd_port
      spu_rf_bypass #(
         .NUM_WR (NUM_WR),
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W)
      ) u_bypass (
         .array_word (r_mem[rd_addr[r]]),
         .wr_en      (w_wr_en_run),
         .wr_addr    (wr_addr),
         .wr_data    (wr_data),
         .rd_addr    (rd_addr[r]),
         .rd_data    (w_byp[r])
      );
      assign rd_data[r] = (r_state == RUN) ? w_byp[r] : '0;
   end

endmodule

`default_nettype wire
